// File: rtl/param_loader_pkg.sv
// param_loader_pkg: shared definitions for the CNN parameter loader.
// Holds the loader state encoding and the default RAM address of the
// filter-start-offset header (high byte; the low byte follows it).
package param_loader_pkg;

  // Default RAM address of the filter-start-offset high byte.
  localparam int HDR_OFS_ADDR_DEF = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_HI     = 3'd1,
    RD_LO     = 3'd2,
    RD_CAP    = 3'd3,
    WAIT_WORD = 3'd4,
    WR_HI     = 3'd5,
    WR_LO     = 3'd6,
    FIN       = 3'd7
  } state_e;

endpackage

// File: rtl/param_loader.sv
// param_loader: streams 16-bit big-endian CNN parameter words into a byte RAM
// starting at a 16-bit offset read from the RAM header. Image streams (cnn=0)
// are ignored.
// Ports: clk/RST (async active-high), load/cnn window control, din/din_valid/
//   din_ready word input, ram_addr/ram_wdata/ram_rdata/ram_rd/ram_wr RAM port,
//   busy/done/overflow/byte_count status.
// Optional: define PARAM_LOADER_CHECKSUM_EN to add checksum[15:0], the
//   mod-2^16 sum of words accepted in the current window.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int HDR_OFS_ADDR = HDR_OFS_ADDR_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load,
  input  logic              cnn,
  input  logic [15:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       byte_count
`ifdef PARAM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        ofs_hi_q, ofs_hi_d;
  logic [7:0]        lo_q, lo_d;       // low byte of the word in flight
  logic              full_q, full_d;   // last RAM address already written
  logic              ovf_q, ovf_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  // RAM strobes/address/data are registered against the next state, so they
  // are valid during the state they belong to.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ofs_hi_d = ofs_hi_q;
    lo_d     = lo_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    // Bookkeeping for the byte written (or suppressed) in WR_HI/WR_LO.
    if (state_q == WR_HI || state_q == WR_LO) begin
      if (wr_q) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        // Hold the pointer at the top address; later bytes are dropped.
        if (ptr_q == ADDR_MAX) full_d = 1'b1;
        else                   ptr_d  = ptr_q + ADDR_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (load && cnn) begin
          state_d = RD_HI;
          addr_d  = ADDR_W'(HDR_OFS_ADDR);
          rd_d    = 1'b1;
        end
      end
      RD_HI: begin
        if (!load) begin
          state_d = FIN;
        end else begin
          state_d = RD_LO;
          addr_d  = ADDR_W'(HDR_OFS_ADDR + 1);
          rd_d    = 1'b1;
        end
      end
      RD_LO: begin
        ofs_hi_d = ram_rdata;
        state_d  = load ? RD_CAP : FIN;
      end
      RD_CAP: begin
        ptr_d  = ADDR_W'({ofs_hi_q, ram_rdata});
        cnt_d  = 16'd0;
        full_d = 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
        csum_d = 16'd0;
`endif
        state_d = load ? WAIT_WORD : FIN;
      end
      WAIT_WORD: begin
        if (!load) begin
          state_d = FIN;
        end else if (din_valid) begin
          // din_ready is high here, so this is an accepted word.
          lo_d    = din[7:0];
          addr_d  = ptr_q;
          wdata_d = din[15:8];
          wr_d    = !full_q;
          state_d = WR_HI;
`ifdef PARAM_LOADER_CHECKSUM_EN
          csum_d  = csum_q + din;
`endif
        end
      end
      WR_HI: begin
        addr_d  = ptr_d;
        wdata_d = lo_q;
        wr_d    = !full_d;
        state_d = WR_LO;
      end
      WR_LO: begin
        state_d = load ? WAIT_WORD : FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ofs_hi_q <= 8'd0;
      lo_q     <= 8'd0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 16'd0;
      addr_q   <= '0;
      wdata_q  <= 8'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum_q   <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ofs_hi_q <= ofs_hi_d;
      lo_q     <= lo_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
`ifdef PARAM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Ready follows load directly so a falling load stops acceptance at once.
  assign din_ready  = (state_q == WAIT_WORD) && load;
  assign busy       = (state_q != IDLE);
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign ram_rd     = rd_q;
  assign ram_wr     = wr_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign byte_count = cnt_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader: self-checking bench for param_loader with a byte-RAM model
// and a scoreboard of expected RAM writes.
module tb_param_loader;

  logic        clk;
  logic        RST;
  logic        load;
  logic        cnn;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_rd;
  logic        ram_wr;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] byte_count;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  param_loader #(.ADDR_W(16), .HDR_OFS_ADDR(2)) dut (
    .clk(clk), .RST(RST), .load(load), .cnn(cnn), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rd(ram_rd),
    .ram_wr(ram_wr), .busy(busy), .done(done), .overflow(overflow),
    .byte_count(byte_count)
`ifdef PARAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RAM model and write/read monitor.
  logic [7:0]  mem [0:65535];
  logic [23:0] wr_log [$];   // {addr, data} as seen by the RAM
  logic [23:0] exp_q  [$];   // {addr, data} expected
  int          cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0, rw_both = 0;
  int          acc_cyc = 0, last_lat = -1;
  bit          lat_pend = 0, rd_pend = 0;
  logic [15:0] first_rd_addr = 16'h0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_rd && ram_wr) rw_both = rw_both + 1;
    if (ram_wr) begin
      mem[ram_addr] = ram_wdata;
      wr_log.push_back({ram_addr, ram_wdata});
      wr_cnt = wr_cnt + 1;
      if (lat_pend) begin
        last_lat = cyc - acc_cyc;
        lat_pend = 0;
      end
    end
    if (ram_rd) begin
      ram_rdata <= mem[ram_addr];
      rd_cnt = rd_cnt + 1;
      if (rd_pend) begin
        first_rd_addr = ram_addr;
        rd_pend = 0;
      end
    end
    if (din_valid && din_ready) begin
      acc_cnt = acc_cnt + 1;
      acc_cyc = cyc;
      lat_pend = 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  // Scoreboard model state.
  logic [15:0] exp_ptr;
  bit          exp_full;
  logic [15:0] exp_csum;
  int          done_base;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] b);
    if (!exp_full) begin
      exp_q.push_back({exp_ptr, b});
      if (exp_ptr == 16'hFFFF) exp_full = 1;
      else exp_ptr = exp_ptr + 16'd1;
    end
  endtask

  task automatic start_window(input logic [15:0] ofs);
    mem[2] = ofs[15:8];
    mem[3] = ofs[7:0];
    exp_ptr = ofs;
    exp_full = 0;
    exp_csum = 16'h0;
    exp_q.delete();
    wr_log.delete();
    done_base = done_cnt;
    load = 1'b1;
    cnn = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n;
    din = w;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (!din_ready) begin
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, din_ready=%b required 1", w, din_ready);
      din_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_exp(w[15:8]);
      push_exp(w[7:0]);
      exp_csum = exp_csum + w;
      @(negedge clk);
      din_valid = 1'b0;
    end
  endtask

  task automatic end_window();
    int n;
    load = 1'b0;
    n = 0;
    while (done_cnt == done_base && n < 20) begin
      tick(1);
      n++;
    end
    tick(3);
    checks++;
    if (done_cnt !== done_base + 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d required 1", done_cnt - done_base);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_fin: busy=%b required 0", busy);
    end
  endtask

  task automatic compare_writes();
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_count: got %0d writes required %0d", wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
      checks++;
      if (wr_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL write_%0d: got addr/data %h required %h", i, wr_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(2);
    checks++;
    if ({busy, din_ready, ram_rd, ram_wr, done, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {busy, din_ready, ram_rd, ram_wr, done, overflow});
    end
    checks++;
    if ({ram_addr, ram_wdata, byte_count} !== 40'h0) begin
      errors++;
      $display("FAIL reset_values: addr=%h wdata=%h count=%h required 0", ram_addr, ram_wdata, byte_count);
    end
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    start_window(16'h000B);
    send_word(16'hA55A);
    tick(3);
    checks++;
    if (byte_count !== 16'd2) begin
      errors++;
      $display("FAIL basic_count: got %0d required 2", byte_count);
    end
    checks++;
    if (last_lat !== 1) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles required 1", last_lat);
    end
    end_window();
    compare_writes();
    checks++;
    if (mem[11] !== 8'hA5 || mem[12] !== 8'h5A) begin
      errors++;
      $display("FAIL basic_ram: got %h %h required a5 5a", mem[11], mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    start_window(16'h000B);
    send_word(16'h0102);
    send_word(16'h0304);
    send_word(16'h0506);
    end_window();
    compare_writes();
    for (int i = 0; i < 6; i++) begin
      want = 8'(i + 1);
      checks++;
      if (mem[11 + i] !== want) begin
        errors++;
        $display("FAIL b2b_ram_%0d: got %h required %h", 11 + i, mem[11 + i], want);
      end
    end
    checks++;
    if (byte_count !== 16'd6) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 6", byte_count);
    end
  endtask

  task automatic test_cnn_ignored();
    int rd0, wr0, busy_seen;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    busy_seen = 0;
    load = 1'b1;
    cnn = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL image_busy: busy high %0d cycles required 0", busy_seen);
    end
    checks++;
    if (rd_cnt != rd0 || wr_cnt != wr0) begin
      errors++;
      $display("FAIL image_ram: got %0d reads %0d writes required 0 0", rd_cnt - rd0, wr_cnt - wr0);
    end
    load = 1'b0;
    tick(2);
  endtask

  task automatic test_abort_header();
    start_window(16'h0040);
    tick(1);
    end_window();
    compare_writes();
  endtask

  task automatic test_overflow();
    int acc0;
    mem[0] = 8'h77;
    acc0 = acc_cnt;
    start_window(16'hFFFF);
    send_word(16'h1234);
    send_word(16'h5678);
    tick(3);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got %b required 1", overflow);
    end
    checks++;
    if (acc_cnt - acc0 != 2) begin
      errors++;
      $display("FAIL overflow_accept: got %0d accepted required 2", acc_cnt - acc0);
    end
    checks++;
    if (byte_count !== 16'd1) begin
      errors++;
      $display("FAIL overflow_count: got %0d required 1", byte_count);
    end
    end_window();
    compare_writes();
    checks++;
    if (mem[16'hFFFF] !== 8'h12 || mem[0] !== 8'h77) begin
      errors++;
      $display("FAIL overflow_ram: got top=%h zero=%h required 12 77", mem[16'hFFFF], mem[0]);
    end
  endtask

  task automatic test_reset_mid();
    start_window(16'h0020);
    send_word(16'hBEEF);
    tick(1);   // now in WR_LO
    RST = 1'b1;
    #1;
    checks++;
    if ({busy, din_ready, ram_rd, ram_wr, done, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_flags: got %b required 000000", {busy, din_ready, ram_rd, ram_wr, done, overflow});
    end
    checks++;
    if ({ram_addr, ram_wdata, byte_count} !== 40'h0) begin
      errors++;
      $display("FAIL midreset_values: addr=%h wdata=%h count=%h required 0", ram_addr, ram_wdata, byte_count);
    end
    load = 1'b0;
    cnn = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(1);
    rd_pend = 1;
    start_window(16'h0030);
    send_word(16'hC0DE);
    end_window();
    checks++;
    if (first_rd_addr !== 16'h0002) begin
      errors++;
      $display("FAIL restart_header: first read addr %h required 0002", first_rd_addr);
    end
    compare_writes();
    checks++;
    if (mem[16'h30] !== 8'hC0 || mem[16'h31] !== 8'hDE) begin
      errors++;
      $display("FAIL restart_ram: got %h %h required c0 de", mem[16'h30], mem[16'h31]);
    end
  endtask

`ifdef PARAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_window(16'h0100);
    send_word(16'hFFFF);
    send_word(16'h0002);
    tick(3);
    checks++;
    if (checksum !== 16'h0001 || checksum !== exp_csum) begin
      errors++;
      $display("FAIL checksum: got %h required 0001 (model %h)", checksum, exp_csum);
    end
    end_window();
  endtask
`endif

  initial begin
    RST = 1'b1;
    load = 1'b0;
    cnn = 1'b0;
    din = 16'h0;
    din_valid = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    test_reset();
    test_basic();
    test_back_to_back();
    test_cnn_ignored();
    test_abort_header();
    test_overflow();
    test_reset_mid();
`ifdef PARAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif

    checks++;
    if (rw_both != 0) begin
      errors++;
      $display("FAIL rd_wr_exclusive: both strobes high %0d cycles required 0", rw_both);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 Parameter: ADDR_W, default 16, RAM address width.
REQ-002 Parameter: HDR_OFS_ADDR, default 2, RAM address of the filter-start-offset high byte; the low byte is at HDR_OFS_ADDR+1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  load window; high while a parameter stream is being delivered.
REQ-006 cnn  input  1  1 = CNN parameter stream; 0 = image stream, which this block ignores.
REQ-007 din  input  16  parameter word, big-endian byte order.
REQ-008 din_valid  input  1  din holds a valid word this cycle.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 ram_addr  output  ADDR_W  RAM address.
REQ-011 ram_wdata  output  8  RAM write byte.
REQ-012 ram_rdata  input  8  RAM read byte; valid one cycle after ram_rd.
REQ-013 ram_rd / ram_wr  output  1 each  RAM read and write strobes; never high together.
REQ-014 busy  output  1  block is in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when a load window completes.
REQ-016 overflow  output  1  sticky; a write was attempted past address 2^ADDR_W-1.
REQ-017 byte_count  output  16  bytes written in the current window.

Function
REQ-018 States: IDLE, RD_HI, RD_LO, RD_CAP, WAIT_WORD, WR_HI, WR_LO, FIN.
REQ-019 IDLE -> RD_HI when load && cnn are both high; otherwise the block stays in IDLE.
REQ-020 RD_HI: ram_rd=1, ram_addr=HDR_OFS_ADDR; next state RD_LO.
REQ-021 RD_LO: ram_rd=1, ram_addr=HDR_OFS_ADDR+1, capture ram_rdata as ptr[15:8]; next state RD_CAP.
REQ-022 RD_CAP: capture ram_rdata as ptr[7:0], clear byte_count; next state WAIT_WORD.
REQ-023 din_ready SHALL be high only in WAIT_WORD while load is high.
REQ-024 A word is accepted when din_valid && din_ready; din is latched, and the next state is WR_HI.
REQ-025 WR_HI: ram_wr=1, ram_addr=ptr, ram_wdata=word[15:8], then ptr+1; next state WR_LO.
REQ-026 WR_LO: ram_wr=1, ram_addr=ptr, ram_wdata=word[7:0], then ptr+1; next state WAIT_WORD.
REQ-027 Throughput is at most 1 word per 2 cycles; the first RAM write occurs 1 cycle after acceptance.
REQ-028 byte_count increments by 1 on each ram_wr and saturates at 16'hFFFF.
REQ-029 If ptr is 2^ADDR_W-1 after a write, further writes are suppressed (ram_wr=0), overflow is set, and acceptance continues so the upstream source does not stall.
REQ-030 load falling in WAIT_WORD SHALL cause a transition to FIN; load falling in WR_HI or WR_LO lets the current word complete, then FIN.
REQ-031 load falling in RD_HI, RD_LO or RD_CAP SHALL cause a transition to FIN with no RAM write.
REQ-032 FIN: done=1 for one cycle; next state IDLE. A new window requires load to be low for at least 1 cycle.
REQ-033 cnn changing mid-window has no effect; it is sampled only in IDLE.
REQ-034 din_valid without din_ready SHALL be ignored; no word is lost if the source holds din until ready.

Reset
REQ-035 RST high asynchronously forces state=IDLE; ptr, byte_count, din_ready, ram_rd, ram_wr, busy, done and overflow go to 0; ram_addr and ram_wdata go to 0.
REQ-036 Reset during WR_HI or WR_LO abandons the word; a partial byte may already be in RAM.

Configuration
REQ-037 Macro PARAM_LOADER_CHECKSUM_EN defined: add output checksum[15:0], the mod-2^16 sum of accepted words, cleared in RD_CAP and by reset.
REQ-038 PARAM_LOADER_CHECKSUM_EN undefined: no checksum port and no adder.

Structure
REQ-039 Package param_loader_pkg holds the state enumeration and the HDR_OFS_ADDR default constant.
REQ-040 The block has no sub-module; it is a single FSM plus a datapath, about 150-250 lines of RTL.

Verification
REQ-041 RAM[2]=0x00, RAM[3]=0x0B; load=cnn=1; word 0xA55A -> RAM[11]=0xA5, RAM[12]=0x5A, byte_count=2.
REQ-042 Three words (0x0102, 0x0304, 0x0506) sent back-to-back on ready, then load=0 -> RAM[11..16]=01..06, then one done pulse.
REQ-043 load=1 with cnn=0 -> busy=0, no ram_rd and no ram_wr for 50 cycles.
REQ-044 Offset 0xFFFF, two words -> only RAM[0xFFFF]=high byte of the first word; overflow=1, and both words are accepted.
REQ-045 RST asserted in WR_LO -> all outputs 0 in the same cycle; a new window restarts at the header read.
REQ-046 With PARAM_LOADER_CHECKSUM_EN: words 0xFFFF and 0x0002 -> checksum=0x0001.
